execute: RTL and testbench

- Consumer end of the decode→execute interface: takes the registered decode outputs (alu_fns_sel, regD_addr, pc_exe) plus GPR read data for regA/regB, computes the result and drives the GPR write-back port.
- ADD/OR/AND/XOR complete in one cycle.
- MULTIPLY runs on an iterative shift-add unit and back-pressures fetch/decode via stall_exe. The top level ORs stall_exe into the decode stall.

---
 rtl/execute_pkg.sv | 54 +++++
 rtl/execute_if.sv | 28 ++
 rtl/execute_mul_iter.sv | 56 +++++
 rtl/execute.sv | 148 ++++++++++++++
 tb/tb_execute.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: datapath width, ALU op codes, FSM states.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Macro FAST_MUL_EN: when defined, MULT is treated as a single-cycle op by the helpers below.
package execute_pkg;

    localparam int DW = 32;               // datapath width
    localparam int CW = $clog2(DW);       // multiplier iteration counter width

    // ALU op codes, shared with decode. Any code not listed is a NOOP.
    localparam logic [3:0] ALU_NOOP = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_MULT = 4'b0110;

    typedef enum logic [1:0] {
        EXE_IDLE = 2'd0,
        EXE_BUSY = 2'd1,
        EXE_DONE = 2'd2
    } exe_state_t;

    // Ops that write back one clock after being presented.
    function automatic logic is_single(input logic [3:0] op);
        logic r;
        r = (op == ALU_ADD) || (op == ALU_OR) || (op == ALU_AND) || (op == ALU_XOR);
`ifdef FAST_MUL_EN
        r = r || (op == ALU_MULT);
`endif
        return r;
    endfunction

    // Single-cycle result. The multiply is only present in the fast build so the
    // iterative build does not carry a combinational multiplier.
    function automatic logic [DW-1:0] alu_calc(input logic [3:0]    op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            ALU_NOOP: r = '0;
            ALU_ADD:  r = a + b;          // wraps modulo 2^DW
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_XOR:  r = a ^ b;
`ifdef FAST_MUL_EN
            ALU_MULT: r = a * b;          // low DW bits of the product
`endif
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_if.sv
// Decode->execute operand bus plus GPR write-back and the execute stall.
// Latency: n/a (wiring only).
// Backpressure: stall_exe from execute freezes the decode side (master).
// Ports: master = decode/GPR side (drives op and operands), slave = execute.
interface execute_if;
    import execute_pkg::*;

    logic [3:0]    alu_fns_sel;
    logic [DW-1:0] regA_data;
    logic [DW-1:0] regB_data;
    logic [4:0]    regD_addr;
    logic [DW-1:0] pc_exe;
    logic          stall_exe;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] pc_wb;

    modport master (
        output alu_fns_sel, regA_data, regB_data, regD_addr, pc_exe,
        input  stall_exe, wb_en, wb_addr, wb_data, pc_wb
    );

    modport slave (
        input  alu_fns_sel, regA_data, regB_data, regD_addr, pc_exe,
        output stall_exe, wb_en, wb_addr, wb_data, pc_wb
    );
endinterface

// File: rtl/execute_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, low DW bits kept.
// Latency: start edge loads operands, then DW clocks; done is high during the last one.
// Backpressure: start is ignored while busy; the owner must hold off new requests.
// Ports: clock, reset (sync, active-high), start, a, b -> busy, done, product.
module execute_mul_iter
    import execute_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product
);

    logic [CW-1:0] cnt;
    logic [DW-1:0] a_sh;     // A << cnt
    logic [DW-1:0] b_sh;     // B >> cnt, so b_sh[0] is B[cnt]
    logic [DW-1:0] acc;
    logic          busy_q;

    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            cnt    <= '0;
            a_sh   <= a;
            b_sh   <= b;
            acc    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;       // wraps back to 0 after the last iteration
            if (cnt == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt == LAST);
    assign product = acc;

endmodule

// File: rtl/execute.sv
// Execute stage: ALU ops and multiply, result registered onto the GPR write-back port.
// Latency: ADD/OR/AND/XOR 1 clock; MULT DW+2 clocks (1 clock with FAST_MUL_EN).
// Backpressure: stall_exe (combinational) holds decode for DW+1 cycles of a MULT.
// Ports: clock, reset (sync, active-high), exe (execute_if.slave).
// Macro FAST_MUL_EN: single-cycle combinational multiply, no FSM, stall_exe tied low.
module execute
    import execute_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    execute_if.slave  exe
);

`ifdef FAST_MUL_EN

    assign exe.stall_exe = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            exe.wb_en   <= 1'b0;
            exe.wb_addr <= '0;
            exe.wb_data <= '0;
            exe.pc_wb   <= '0;
        end else begin
            exe.wb_en <= 1'b0;
            if (is_single(exe.alu_fns_sel)) begin
                // r0 is never written, but the op still completes
                exe.wb_en   <= (exe.regD_addr != 5'd0);
                exe.wb_addr <= exe.regD_addr;
                exe.wb_data <= alu_calc(exe.alu_fns_sel, exe.regA_data, exe.regB_data);
                exe.pc_wb   <= exe.pc_exe;
            end
        end
    end

`else

    exe_state_t    state;
    exe_state_t    state_nxt;
    logic          stall;
    logic          mul_start;
    logic          ld_single;
    logic          ld_mul;
    logic          mul_busy;
    logic          mul_done;
    logic [DW-1:0] mul_product;
    logic [4:0]    rd_q;
    logic [DW-1:0] pc_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EXE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            EXE_IDLE: begin
                if (exe.alu_fns_sel == ALU_MULT) begin
                    state_nxt = EXE_BUSY;
                end
            end
            EXE_BUSY: begin
                if (mul_done) begin
                    state_nxt = EXE_DONE;
                end else if (!mul_busy) begin
                    // unit not running: fall back rather than stall forever
                    state_nxt = EXE_IDLE;
                end
            end
            EXE_DONE: state_nxt = EXE_IDLE;
            default:  state_nxt = EXE_IDLE;
        endcase
    end

    // Outputs. In DONE decode still shows the finished MULT; it is not re-issued.
    always_comb begin
        stall     = 1'b0;
        mul_start = 1'b0;
        ld_single = 1'b0;
        ld_mul    = 1'b0;
        case (state)
            EXE_IDLE: begin
                stall     = (exe.alu_fns_sel == ALU_MULT);
                mul_start = (exe.alu_fns_sel == ALU_MULT);
                ld_single = is_single(exe.alu_fns_sel);
            end
            EXE_BUSY: stall  = 1'b1;
            EXE_DONE: ld_mul = 1'b1;
            default: ;
        endcase
    end

    assign exe.stall_exe = stall;

    execute_mul_iter u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (exe.regA_data),
        .b       (exe.regB_data),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Destination and PC of the multiply, captured with the operands
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= '0;
            pc_q <= '0;
        end else if (mul_start) begin
            rd_q <= exe.regD_addr;
            pc_q <= exe.pc_exe;
        end
    end

    // Write-back register; address/data/pc hold when nothing completes
    always_ff @(posedge clock) begin
        if (reset) begin
            exe.wb_en   <= 1'b0;
            exe.wb_addr <= '0;
            exe.wb_data <= '0;
            exe.pc_wb   <= '0;
        end else begin
            exe.wb_en <= 1'b0;
            if (ld_single) begin
                exe.wb_en   <= (exe.regD_addr != 5'd0);
                exe.wb_addr <= exe.regD_addr;
                exe.wb_data <= alu_calc(exe.alu_fns_sel, exe.regA_data, exe.regB_data);
                exe.pc_wb   <= exe.pc_exe;
            end else if (ld_mul) begin
                exe.wb_en   <= (rd_q != 5'd0);
                exe.wb_addr <= rd_q;
                exe.wb_data <= mul_product;
                exe.pc_wb   <= pc_q;
            end
        end
    end

`endif

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: reset, table vectors, multiply sequences, random ops.
// Latency: n/a.
// Backpressure: decode side honours stall_exe by holding the MULT until it completes.
module tb_execute;
    import execute_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    execute_if ifc();

    execute dut (
        .clock (clock),
        .reset (reset),
        .exe   (ifc)
    );

`ifdef FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Last architecturally known write-back values (for NOOP hold checks)
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_pc;
    bit            m_known;

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [4:0]    rd;
        logic [DW-1:0] pc;
        logic          exp_en;
        logic [4:0]    exp_addr;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] exp_pc;
        bit            chk_dat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: results straight from the op definitions
    function automatic logic [DW-1:0] ref_result(input logic [3:0] op,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        case (op)
            ALU_ADD:  return a + b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_XOR:  return a ^ b;
            ALU_MULT: begin
                p = (2*DW)'(a) * (2*DW)'(b);
                return p[DW-1:0];
            end
            default:  return '0;
        endcase
    endfunction

    function automatic bit ref_writes_now(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_OR) || (op == ALU_AND) ||
               (op == ALU_XOR) || (FAST && op == ALU_MULT);
    endfunction

    task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] rd, input logic [DW-1:0] pc);
        @(negedge clock);
        ifc.alu_fns_sel = op;
        ifc.regA_data   = a;
        ifc.regB_data   = b;
        ifc.regD_addr   = rd;
        ifc.pc_exe      = pc;
    endtask

    task automatic expect_write(input string name, input logic [4:0] rd,
                                input logic [DW-1:0] data, input logic [DW-1:0] pc);
        chk({name, ".wb_en"}, 64'(ifc.wb_en), 64'(rd != 5'd0));
        if (rd != 5'd0) begin
            chk({name, ".wb_addr"}, 64'(ifc.wb_addr), 64'(rd));
            chk({name, ".wb_data"}, 64'(ifc.wb_data), 64'(data));
            chk({name, ".pc_wb"},   64'(ifc.pc_wb),   64'(pc));
            m_addr  = rd;
            m_data  = data;
            m_pc    = pc;
            m_known = 1'b1;
        end else begin
            m_known = 1'b0;
        end
    endtask

    // One op that is not a slow MULT: one cycle in, result after the edge
    task automatic single(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [4:0] rd, input logic [DW-1:0] pc);
        drive(op, a, b, rd, pc);
        #1 chk({name, ".stall"}, 64'(ifc.stall_exe), 64'd0);
        @(posedge clock);
        #1;
        if (ref_writes_now(op)) begin
            expect_write(name, rd, ref_result(op, a, b), pc);
        end else begin
            chk({name, ".wb_en"}, 64'(ifc.wb_en), 64'd0);
            if (m_known) begin
                chk({name, ".hold_data"}, 64'(ifc.wb_data), 64'(m_data));
                chk({name, ".hold_addr"}, 64'(ifc.wb_addr), 64'(m_addr));
                chk({name, ".hold_pc"},   64'(ifc.pc_wb),   64'(m_pc));
            end
        end
    endtask

    // MULT as decode sees it: held while stalled, plus the one un-stalled cycle
    task automatic run_mult(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [4:0] rd, input logic [DW-1:0] pc, input bit scramble);
        logic [DW-1:0] sa;
        logic [DW-1:0] sb;
        if (FAST) begin
            single(name, ALU_MULT, a, b, rd, pc);
        end else begin
            for (int k = 0; k <= DW + 1; k++) begin
                sa = (scramble && k >= 1 && k <= DW) ? $urandom : a;
                sb = (scramble && k >= 1 && k <= DW) ? $urandom : b;
                drive(ALU_MULT, sa, sb, rd, pc);
                #1 chk({name, ".stall"}, 64'(ifc.stall_exe), 64'(k <= DW));
                @(posedge clock);
                #1;
                if (k <= DW) begin
                    chk({name, ".early_wb"}, 64'(ifc.wb_en), 64'd0);
                end else begin
                    expect_write(name, rd, ref_result(ALU_MULT, a, b), pc);
                end
            end
        end
    endtask

    vec_t vecs[9];
    int   wr_seen;

    initial begin
        ifc.alu_fns_sel = ALU_ADD;
        ifc.regA_data   = 32'd1;
        ifc.regB_data   = 32'd2;
        ifc.regD_addr   = 5'd5;
        ifc.pc_exe      = '0;
        m_addr = '0; m_data = '0; m_pc = '0; m_known = 1'b1;

        // Reset held two cycles with ADD presented
        repeat (2) begin
            @(posedge clock);
            #1;
            chk("reset.wb_en",   64'(ifc.wb_en),     64'd0);
            chk("reset.wb_data", 64'(ifc.wb_data),   64'd0);
            chk("reset.wb_addr", 64'(ifc.wb_addr),   64'd0);
            chk("reset.pc_wb",   64'(ifc.pc_wb),     64'd0);
            chk("reset.stall",   64'(ifc.stall_exe), 64'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Single-cycle vectors; NOOP rows expect the previous write held
        vecs[0] = '{ALU_ADD, 32'hFFFFFFFF, 32'h2, 5'd5, 32'h10, 1'b1, 5'd5, 32'h1, 32'h10, 1'b1};
        vecs[1] = '{ALU_NOOP, 32'h123, 32'h456, 5'd9, 32'h14, 1'b0, 5'd5, 32'h1, 32'h10, 1'b1};
        vecs[2] = '{ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd1, 32'h18, 1'b1, 5'd1, 32'hFFF0FFF0, 32'h18, 1'b1};
        vecs[3] = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd2, 32'h1C, 1'b1, 5'd2, 32'hF000F000, 32'h1C, 1'b1};
        vecs[4] = '{ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 32'h20, 1'b1, 5'd3, 32'h0FF00FF0, 32'h20, 1'b1};
        vecs[5] = '{4'h2, 32'h1, 32'h1, 5'd6, 32'h24, 1'b0, 5'd3, 32'h0FF00FF0, 32'h20, 1'b1};
        vecs[6] = '{4'hF, 32'h1, 32'h1, 5'd6, 32'h28, 1'b0, 5'd3, 32'h0FF00FF0, 32'h20, 1'b1};
        vecs[7] = '{ALU_ADD, 32'h7, 32'h8, 5'd31, 32'h2C, 1'b1, 5'd31, 32'd15, 32'h2C, 1'b1};
        vecs[8] = '{ALU_ADD, 32'h7, 32'h8, 5'd0, 32'h30, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].pc);
            #1 chk($sformatf("vec%0d.stall", i), 64'(ifc.stall_exe), 64'd0);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d.wb_en", i), 64'(ifc.wb_en), 64'(vecs[i].exp_en));
            if (vecs[i].chk_dat) begin
                chk($sformatf("vec%0d.wb_addr", i), 64'(ifc.wb_addr), 64'(vecs[i].exp_addr));
                chk($sformatf("vec%0d.wb_data", i), 64'(ifc.wb_data), 64'(vecs[i].exp_data));
                chk($sformatf("vec%0d.pc_wb", i),   64'(ifc.pc_wb),   64'(vecs[i].exp_pc));
            end
        end
        m_known = 1'b0;

        // Multiply 12345 x 678, then nothing further written
        run_mult("mul1", 32'd12345, 32'd678, 5'd7, 32'h40, 1'b0);
        chk("mul1.const", 64'(ifc.wb_data), 64'd8369910);
        single("mul1.after", ALU_NOOP, 32'd12345, 32'd678, 5'd7, 32'h44);

        // Truncation, back-to-back multiplies, single-cycle op straight after
        run_mult("mul_trunc", 32'h10000, 32'h10000, 5'd8, 32'h48, 1'b0);
        chk("mul_trunc.const", 64'(ifc.wb_data), 64'd0);
        run_mult("mul_b2b", 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 32'h4C, 1'b0);
        single("add_after_mul", ALU_ADD, 32'd40, 32'd2, 5'd10, 32'h50);
        run_mult("mul_r0", 32'd3, 32'd5, 5'd0, 32'h54, 1'b0);
        run_mult("mul_3x5", 32'd3, 32'd5, 5'd4, 32'h58, 1'b0);
        chk("mul_3x5.const", 64'(ifc.wb_data), 64'd15);

        // Random op stream against the reference
        for (int n = 0; n < 80; n++) begin
            logic [3:0]    op;
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) op = ALU_MULT;
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if (op == ALU_MULT && !FAST) begin
                run_mult($sformatf("rmul%0d", n), a, b, 5'($urandom_range(0, 31)), $urandom, 1'b1);
            end else begin
                single($sformatf("rop%0d", n), op, a, b, 5'($urandom_range(0, 31)), $urandom);
            end
        end

        // Reset during iteration 10 of a multiply abandons it
        if (!FAST) begin
            drive(ALU_MULT, 32'h1234, 32'h5678, 5'd9, 32'h80);
            @(posedge clock);                       // operands captured
            for (int i = 0; i < 10; i++) begin      // iterations 0..9
                drive(ALU_MULT, 32'h1234, 32'h5678, 5'd9, 32'h80);
                @(posedge clock);
            end
            @(negedge clock);
            reset = 1'b1;
            @(posedge clock);
            #1;
            chk("abort.wb_en", 64'(ifc.wb_en), 64'd0);
            chk("abort.wb_data", 64'(ifc.wb_data), 64'd0);
            @(negedge clock);
            reset = 1'b0;
            ifc.alu_fns_sel = ALU_NOOP;
            #1 chk("abort.stall", 64'(ifc.stall_exe), 64'd0);
            wr_seen = 0;
            repeat (DW + 4) begin
                @(posedge clock);
                #1;
                if (ifc.wb_en === 1'b1) wr_seen++;
            end
            chk("abort.no_write", 64'(wr_seen), 64'd0);
            m_addr = '0; m_data = '0; m_pc = '0; m_known = 1'b1;
            single("abort.noop", ALU_NOOP, 32'h1, 32'h1, 5'd3, 32'h84);
            run_mult("abort.recover", 32'd7, 32'd6, 5'd11, 32'h88, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
